// File: rtl/ram_dp_clr.sv
//------------------------------------------------------------------------------
// Module   : ram_dp_clr
// Simple-dual-port RAM with per-lane write enables, registered read + valid,
// and a hardware clear sweep run after reset or on clr_i.
// Optional : define RAM_BYPASS_EN for write-first same-address reads.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ram_dp_clr #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int LANE_W = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clr_i,
  output logic                       busy_o,
  input  logic                       write_ena_i,
  input  logic [DATA_W/LANE_W-1:0]   w_be_i,
  input  logic [ADDR_W-1:0]          w_addr_i,
  input  logic [DATA_W-1:0]          bus_data_i,
  input  logic                       rd_ena_i,
  input  logic [ADDR_W-1:0]          r_addr_i,
  output logic [DATA_W-1:0]          bus_data_o,
  output logic                       rd_valid_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NLANE = DATA_W / LANE_W;
  localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [NLANE-1:0]    mem_be;
  logic [DATA_W-1:0]   rd_word;

  logic [DATA_W-1:0]   mem [DEPTH];

`ifdef RAM_BYPASS_EN
  logic [DATA_W-1:0]   be_mask;

  for (genvar j = 0; j < NLANE; j++) begin : g_lane_mask
    assign be_mask[j*LANE_W +: LANE_W] = {LANE_W{w_be_i[j]}};
  end

  // Same-address write merges into the read result (write-first).
  assign rd_word = (write_ena_i && (w_addr_i == r_addr_i))
                 ? ((bus_data_i & be_mask) | (mem[r_addr_i] & ~be_mask))
                 : mem[r_addr_i];
`else
  assign rd_word = mem[r_addr_i];
`endif

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    busy_d    = busy_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = w_addr_i;
    mem_wdata = bus_data_i;
    mem_be    = w_be_i;

    if (!rst_i) begin
      case (state_q)
        ST_CLEAR: begin
          mem_we    = 1'b1;
          mem_addr  = clr_cnt_q;
          mem_wdata = '0;
          mem_be    = '1;
          if (clr_cnt_q == C_LAST_ADDR) begin
            state_d = ST_READY;
            busy_d  = 1'b0;
          end else begin
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
          end
        end
        ST_READY: begin
          if (clr_i) begin
            state_d   = ST_CLEAR;
            clr_cnt_d = '0;
            busy_d    = 1'b1;
          end else begin
            mem_we = write_ena_i;
            if (rd_ena_i) begin
              rdata_d  = rd_word;
              rvalid_d = 1'b1;
            end
          end
        end
        default: begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
          busy_d    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      busy_q    <= 1'b1;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      busy_q    <= busy_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
    end
  end

  // Array has no reset; the sweep that follows reset zeroes it.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int j = 0; j < NLANE; j++) begin
        if (mem_be[j]) begin
          mem[mem_addr][j*LANE_W +: LANE_W] <= mem_wdata[j*LANE_W +: LANE_W];
        end
      end
    end
  end

  assign busy_o     = busy_q;
  assign bus_data_o = rdata_q;
  assign rd_valid_o = rvalid_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_dp_clr.sv
//------------------------------------------------------------------------------
// Module   : tb_ram_dp_clr
// Self-checking bench for ram_dp_clr (ADDR_W=4, DATA_W=16, LANE_W=8).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ram_dp_clr;

  localparam int DEPTH = 16;
`ifdef RAM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst, clr, we, rd;
  logic [1:0]  be;
  logic [3:0]  wa, ra;
  logic [15:0] wd;
  logic        busy, rvalid;
  logic [15:0] rdata;

  ram_dp_clr #(.ADDR_W(4), .DATA_W(16), .LANE_W(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .clr_i       (clr),
    .busy_o      (busy),
    .write_ena_i (we),
    .w_be_i      (be),
    .w_addr_i    (wa),
    .bus_data_i  (wd),
    .rd_ena_i    (rd),
    .r_addr_i    (ra),
    .bus_data_o  (rdata),
    .rd_valid_o  (rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: whole-array state plus a count of remaining sweep cycles.
  logic [15:0] m_mem [DEPTH];
  int          m_clear_left;
  logic [15:0] m_rdata;
  logic        m_rvalid;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_zero();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'h0;
  endtask

  task automatic model_edge();
    logic [15:0] w;
    if (rst) begin
      m_clear_left = DEPTH;
      m_rdata      = 16'h0;
      m_rvalid     = 1'b0;
      model_zero();
    end else if (m_clear_left > 0) begin
      m_clear_left--;
      m_rvalid = 1'b0;
    end else if (clr) begin
      m_clear_left = DEPTH;
      m_rvalid     = 1'b0;
      model_zero();
    end else begin
      w = m_mem[wa];
      if (we) begin
        if (be[0]) w[7:0]  = wd[7:0];
        if (be[1]) w[15:8] = wd[15:8];
      end
      m_rvalid = rd;
      if (rd) m_rdata = (BYP && we && (wa == ra)) ? w : m_mem[ra];
      if (we) m_mem[wa] = w;
    end
  endtask

  task automatic cyc(input logic i_rst, input logic i_clr, input logic i_we,
                     input logic [1:0] i_be, input logic [3:0] i_wa,
                     input logic [15:0] i_wd, input logic i_rd, input logic [3:0] i_ra);
    rst = i_rst; clr = i_clr; we = i_we; be = i_be;
    wa = i_wa; wd = i_wd; rd = i_rd; ra = i_ra;
    @(posedge clk);
    model_edge();
    #1;
    chk("busy_model",   {31'b0, busy},   {31'b0, (m_clear_left > 0)});
    chk("rvalid_model", {31'b0, rvalid}, {31'b0, m_rvalid});
    chk("rdata_model",  {16'b0, rdata},  {16'b0, m_rdata});
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0, 1'b0, 4'h0);
  endtask

  // Counts busy-high samples starting from the current one; bounded.
  task automatic count_busy(input bit pulse_we, output int cnt);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      cnt++;
      cyc(1'b0, 1'b0, pulse_we & i[0], 2'b11, 4'(i), 16'hFFFF, 1'b0, 4'h0);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  be;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic        rd;
    logic [3:0]  ra;
    logic        e_valid;
    logic [15:0] e_data;
  } vec_t;

  function automatic vec_t mk(input logic i_we, input logic [1:0] i_be, input logic [3:0] i_wa,
                              input logic [15:0] i_wd, input logic i_rd, input logic [3:0] i_ra,
                              input logic e_v, input logic [15:0] e_d);
    vec_t v;
    v.we = i_we; v.be = i_be; v.wa = i_wa; v.wd = i_wd;
    v.rd = i_rd; v.ra = i_ra; v.e_valid = e_v; v.e_data = e_d;
    return v;
  endfunction

  vec_t vt [17];
  int   cnt;

  initial begin
    vt[0]  = mk(1, 2'b11, 4'd3, 16'hABCD, 0, 4'd0, 0, 16'h0000);
    vt[1]  = mk(1, 2'b01, 4'd3, 16'h1234, 0, 4'd0, 0, 16'h0000);
    vt[2]  = mk(0, 2'b00, 4'd0, 16'h0000, 1, 4'd3, 1, 16'hAB34);
    vt[3]  = mk(0, 2'b00, 4'd0, 16'h0000, 0, 4'd0, 0, 16'hAB34);
    vt[4]  = mk(1, 2'b11, 4'd2, 16'h0011, 0, 4'd0, 0, 16'hAB34);
    vt[5]  = mk(1, 2'b11, 4'd2, 16'h005A, 1, 4'd2, 1, BYP ? 16'h005A : 16'h0011);
    vt[6]  = mk(0, 2'b00, 4'd0, 16'h0000, 1, 4'd2, 1, 16'h005A);
    vt[7]  = mk(1, 2'b11, 4'd0, 16'h0010, 0, 4'd0, 0, 16'h005A);
    vt[8]  = mk(1, 2'b11, 4'd1, 16'h0020, 0, 4'd0, 0, 16'h005A);
    vt[9]  = mk(1, 2'b11, 4'd2, 16'h0030, 0, 4'd0, 0, 16'h005A);
    vt[10] = mk(0, 2'b00, 4'd0, 16'h0000, 1, 4'd0, 1, 16'h0010);
    vt[11] = mk(0, 2'b00, 4'd0, 16'h0000, 1, 4'd1, 1, 16'h0020);
    vt[12] = mk(0, 2'b00, 4'd0, 16'h0000, 1, 4'd2, 1, 16'h0030);
    vt[13] = mk(0, 2'b00, 4'd0, 16'h0000, 0, 4'd0, 0, 16'h0030);
    vt[14] = mk(0, 2'b00, 4'd0, 16'h0000, 0, 4'd0, 0, 16'h0030);
    vt[15] = mk(1, 2'b00, 4'd2, 16'hFFFF, 1, 4'd2, 1, 16'h0030);
    vt[16] = mk(0, 2'b00, 4'd0, 16'h0000, 1, 4'd2, 1, 16'h0030);

    m_clear_left = DEPTH;
    m_rdata      = 16'h0;
    m_rvalid     = 1'b0;
    model_zero();

    // Reset release: busy for exactly DEPTH cycles, then all words read 0.
    cyc(1'b1, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0, 1'b0, 4'h0);
    cyc(1'b1, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0, 1'b0, 4'h0);
    chk("reset_rdata",  {16'b0, rdata},  32'h0);
    chk("reset_rvalid", {31'b0, rvalid}, 32'h0);
    count_busy(1'b0, cnt);
    chk("busy_len_after_reset", cnt, 32'd16);
    for (int a = 0; a < DEPTH; a++) begin
      cyc(1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0, 1'b1, 4'(a));
      chk("init_read_data",  {16'b0, rdata},  32'h0);
      chk("init_read_valid", {31'b0, rvalid}, 32'h1);
    end
    idle();
    chk("valid_drop", {31'b0, rvalid}, 32'h0);

    // Directed lane-merge / read-first / back-to-back vectors.
    for (int i = 0; i < 17; i++) begin
      cyc(1'b0, 1'b0, vt[i].we, vt[i].be, vt[i].wa, vt[i].wd, vt[i].rd, vt[i].ra);
      chk("vec_valid", {31'b0, rvalid}, {31'b0, vt[i].e_valid});
      chk("vec_data",  {16'b0, rdata},  {16'b0, vt[i].e_data});
    end

    // clr_i beats a same-edge write.
    cyc(1'b0, 1'b1, 1'b1, 2'b11, 4'd7, 16'h00FF, 1'b1, 4'd7);
    chk("clr_kills_read", {31'b0, rvalid}, 32'h0);
    count_busy(1'b0, cnt);
    chk("busy_len_after_clr", cnt, 32'd16);
    cyc(1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0, 1'b1, 4'd7);
    chk("addr7_cleared", {16'b0, rdata}, 32'h0);

    // Reset at sweep cycle 9 restarts a full sweep; writes during it ignored.
    cyc(1'b0, 1'b0, 1'b1, 2'b11, 4'd5, 16'hBEEF, 1'b0, 4'h0);
    cyc(1'b0, 1'b1, 1'b0, 2'b00, 4'h0, 16'h0, 1'b0, 4'h0);
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, 1'b1, 2'b11, 4'(i), 16'hFFFF, 1'b0, 4'h0);
    cyc(1'b1, 1'b0, 1'b1, 2'b11, 4'd9, 16'hFFFF, 1'b0, 4'h0);
    cyc(1'b1, 1'b0, 1'b1, 2'b11, 4'd9, 16'hFFFF, 1'b0, 4'h0);
    count_busy(1'b1, cnt);
    chk("busy_len_after_midsweep_reset", cnt, 32'd16);
    for (int a = 0; a < DEPTH; a++) begin
      cyc(1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0, 1'b1, 4'(a));
      chk("post_sweep_zero", {16'b0, rdata}, 32'h0);
    end

    // Randomised traffic against the model.
    for (int n = 0; n < 600; n++) begin
      cyc(($urandom_range(0, 149) == 0), ($urandom_range(0, 59) == 0),
          1'($urandom), 2'($urandom), 4'($urandom), 16'($urandom),
          1'($urandom), 4'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ram_dp_clr.md
Name: ram_dp_clr

Overview:
Parametrised simple-dual-port synchronous RAM: one write port, one read port, one clock. Generalises the basic datapath RAM with per-lane write enables, a registered read with valid flag, and a hardware clear engine. The clear engine zeroes every location after reset or on request. Used as scratch/matrix storage in the numeric datapath, where controllers poll busy_o before issuing accesses.

Parameters:
ADDR_W, 4, address width; depth DEPTH = 2**ADDR_W words
DATA_W, 8, word width in bits
LANE_W, 8, write-lane width; DATA_W must be an integer multiple of LANE_W; NLANE = DATA_W/LANE_W

Ports:
clk_i  in  1  single clock; all state updates on rising edge
rst_i  in  1  synchronous reset, active-high
clr_i  in  1  request a full clear sweep; sampled only in READY
busy_o  out  1  1 while clear sweep in progress; accesses ignored
write_ena_i  in  1  write strobe
w_be_i  in  NLANE  per-lane write enable; bit j covers bits [j*LANE_W +: LANE_W]
w_addr_i  in  ADDR_W  write address
bus_data_i  in  DATA_W  write data
rd_ena_i  in  1  read strobe
r_addr_i  in  ADDR_W  read address
bus_data_o  out  DATA_W  registered read data
rd_valid_o  out  1  1 for exactly the cycle after an accepted read

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- FSM states: CLEAR, READY. A sweep counter clr_cnt has ADDR_W bits.
- On an edge with rst_i=1: state <= CLEAR, clr_cnt <= 0, busy_o <= 1, bus_data_o <= 0, rd_valid_o <= 0. Array contents are not touched by reset itself; they are zeroed by the sweep that follows.
- CLEAR: each edge with rst_i=0 writes 0 to mem[clr_cnt] and increments clr_cnt.
  - On the edge that writes DEPTH-1: state <= READY, busy_o <= 0.
  - busy_o is therefore high for exactly DEPTH cycles after reset release.
  - In CLEAR, write_ena_i, rd_ena_i and clr_i are ignored. rd_valid_o stays 0 and bus_data_o holds its value.
- READY, clr_i=1: state <= CLEAR, clr_cnt <= 0, busy_o <= 1. Any write or read on the same edge is discarded and rd_valid_o <= 0. clr_i has priority over both ports.
- READY write: on an edge with write_ena_i=1, each lane j with w_be_i[j]=1 loads bus_data_i lane j into mem[w_addr_i]. Lanes with w_be_i[j]=0 keep their old value. w_be_i all-zero is a no-op.
- READY read: on an edge with rd_ena_i=1, bus_data_o <= mem[r_addr_i] and rd_valid_o <= 1 (latency 1).
  - If rd_ena_i=0: rd_valid_o <= 0 and bus_data_o holds the last read value.
- Simultaneous read and write to different addresses are independent.
- Same-address read and write on one edge: bus_data_o returns the pre-write word (read-first), unless RAM_BYPASS_EN is defined (see Optional Feature).
- Addresses cover the full DEPTH range, so no out-of-range condition exists. clr_cnt wraps DEPTH-1 -> 0 only through a new clear.
- Reset asserted mid-sweep restarts the sweep from address 0. Reset asserted mid-read forces rd_valid_o <= 0.

Optional Feature:
Macro RAM_BYPASS_EN.
- Defined: on a same-address read and write in READY, bus_data_o returns the merged word. Enabled lanes take bus_data_i; disabled lanes take the old mem contents. This gives write-first behaviour.
- Not defined: read-first; the old word is returned.
- Array update is identical in both builds; only bus_data_o differs.

Test Plan:
1. Reset release, ADDR_W=4 -> busy_o=1 for exactly 16 cycles, then 0. Reads of addresses 0..15 all return 0 with rd_valid_o=1 one cycle after each rd_ena_i.
2. DATA_W=16, LANE_W=8: write 0xABCD to addr 3 with be=2'b11, then 0x1234 with be=2'b01, then read addr 3 -> bus_data_o=0xAB34, rd_valid_o=1 for one cycle.
3. Write 0x5A at addr 2 and read addr 2 on the same edge, after 0x11 was previously stored there -> 0x11 without RAM_BYPASS_EN, 0x5A with it. A later read returns 0x5A in both builds.
4. In READY, assert clr_i together with a write of 0xFF to addr 7 -> write discarded, busy_o=1 for 16 cycles, then addr 7 reads 0.
5. Assert rst_i at sweep cycle 9, hold 2 cycles, release -> busy_o=1 for a full 16 cycles after release. write_ena_i pulses during the sweep leave all words reading 0.
6. Back-to-back reads of addrs 0,1,2 with prior data 0x10,0x20,0x30 -> bus_data_o 0x10,0x20,0x30 on consecutive cycles with rd_valid_o continuously 1. Then drop rd_ena_i -> rd_valid_o=0 and bus_data_o holds 0x30.
